// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair.
// Signed ops run on magnitudes for 32 steps; the signs are applied in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic               is_div;
    logic               sa, sb, dz;
    logic [WIDTH-1:0]   ma, mb, a_raw;
    logic [2*WIDTH-1:0] acc;
    logic [4:0]         cnt;

    logic               signed_op;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] fix_result;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign busy      = (state != IDLE);
    assign signed_op = ~op[0];

    // Multiply: right-shifting accumulator, upper half gets the partial sum.
    // Divide: acc = {remainder, quotient}, dividend bits fed from the top of ma.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mb[0] ? ma : {WIDTH{1'b0}})};
    assign div_diff = {1'b0, acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]} - {2'b00, mb};

    always_comb begin
        prod = acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (sa ^ sb) begin
            prod = -acc;
            quo  = -acc[WIDTH-1:0];
        end
        if (sa)
            rem = -acc[2*WIDTH-1:WIDTH];
        if (!is_div)
            fix_result = prod;
        else if (dz)
            fix_result = {a_raw, {WIDTH{1'b1}}};
        else
            fix_result = {rem, quo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            a_raw  <= '0;
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        sa     <= signed_op & a[WIDTH-1];
                        sb     <= signed_op & b[WIDTH-1];
                        ma     <= (signed_op & a[WIDTH-1]) ? -a : a;
                        mb     <= (signed_op & b[WIDTH-1]) ? -b : b;
                        a_raw  <= a;
                        dz     <= (b == '0);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    if (!is_div) begin
                        mb  <= mb >> 1;
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        ma <= ma << 1;
                        if (!div_diff[WIDTH+1])
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {acc[2*WIDTH-2:WIDTH], ma[WIDTH-1], acc[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_result[2*WIDTH-1:WIDTH];
                    lo    <= fix_result[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
